// File: rtl/sync_vga_gen_param.sv
`default_nettype none
// ============================================================================
//  Module   : sync_vga_gen_param
//  Purpose  : Parametrised VGA timing generator with registered, mutually
//             aligned sync/position/strobe outputs and a frame counter.
//  Revision : 1.0  initial release
// ============================================================================
module sync_vga_gen_param #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 56,
    parameter int   H_PULSE  = 120,
    parameter int   H_BP     = 64,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 37,
    parameter int   V_PULSE  = 6,
    parameter int   V_BP     = 23,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 11,
    parameter int   FRAME_W  = 8
) (
    input  logic               px_clk,
    input  logic               rst_n,
    input  logic               en,
    output logic               hsync,
    output logic               vsync,
    output logic               activevideo,
    output logic [CW-1:0]      x_px,
    output logic [CW-1:0]      y_px,
    output logic               line_start,
    output logic               frame_start,
    output logic               vblank,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_PULSE + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_PULSE + V_BP;

    generate
        if ((H_TOTAL - 1) > (2**CW - 1) || (V_TOTAL - 1) > (2**CW - 1)
            || H_PULSE == 0 || V_PULSE == 0) begin : g_bad_cfg
            $error("sync_vga_gen_param: totals exceed counter width or zero pulse width");
        end
    endgenerate

    // One extra bit so boundaries equal to 2**CW stay representable.
    localparam logic [CW:0] H_LAST   = (CW+1)'(H_TOTAL - 1);
    localparam logic [CW:0] V_LAST   = (CW+1)'(V_TOTAL - 1);
    localparam logic [CW:0] H_ACT    = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] V_ACT    = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] HS_START = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] HS_END   = (CW+1)'(H_ACTIVE + H_FP + H_PULSE);
    localparam logic [CW:0] VS_START = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] VS_END   = (CW+1)'(V_ACTIVE + V_FP + V_PULSE);

    logic [CW-1:0]      r_hc;
    logic [CW-1:0]      r_vc;
    logic [FRAME_W-1:0] r_frame;

    logic [CW:0] w_hx;
    logic [CW:0] w_vx;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_active;
    logic        w_hs_on;
    logic        w_vs_on;
    logic        w_hc_zero;
    logic        w_vc_zero;

    assign w_hx      = {1'b0, r_hc};
    assign w_vx      = {1'b0, r_vc};
    assign w_h_wrap  = (w_hx == H_LAST);
    assign w_v_wrap  = (w_vx == V_LAST);
    assign w_active  = (w_hx < H_ACT) && (w_vx < V_ACT);
    assign w_hs_on   = (w_hx >= HS_START) && (w_hx < HS_END);
    assign w_vs_on   = (w_vx >= VS_START) && (w_vx < VS_END);
    assign w_hc_zero = (r_hc == '0);
    assign w_vc_zero = (r_vc == '0);

    // Outputs are decoded from the pre-increment counter state on the same
    // edge, so all of them describe one (hc, vc) pair.
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hc        <= '0;
            r_vc        <= '0;
            r_frame     <= '0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            activevideo <= 1'b0;
            x_px        <= '0;
            y_px        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
            frame_cnt   <= '0;
        end else if (en) begin
            r_hc <= w_h_wrap ? '0 : r_hc + 1'b1;
            if (w_h_wrap) begin
                r_vc <= w_v_wrap ? '0 : r_vc + 1'b1;
                if (w_v_wrap) begin
                    r_frame <= r_frame + 1'b1;
                end
            end
            hsync       <= w_hs_on ? HS_POL : ~HS_POL;
            vsync       <= w_vs_on ? VS_POL : ~VS_POL;
            activevideo <= w_active;
            x_px        <= w_active ? r_hc : '0;
            y_px        <= w_active ? r_vc : '0;
            line_start  <= w_hc_zero;
            frame_start <= w_hc_zero && w_vc_zero;
            vblank      <= (w_vx >= V_ACT);
            frame_cnt   <= r_frame;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_vga_gen_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_vga_gen_param
//  Purpose  : Directed self-checking bench: default timing over two lines,
//             small config over several frames with en pauses and async reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sync_vga_gen_param;

    logic px_clk = 1'b0;
    always #5 px_clk = ~px_clk;

    logic rst_n;
    logic en_b;
    logic en_s;

    logic        b_hsync, b_vsync, b_av, b_ls, b_fs, b_vb;
    logic [10:0] b_x, b_y;
    logic [7:0]  b_fc;

    logic        s_hsync, s_vsync, s_av, s_ls, s_fs, s_vb;
    logic [3:0]  s_x, s_y;
    logic [1:0]  s_fc;

    int vectors     = 0;
    int miscompares = 0;
    int hpos        = 0;

    sync_vga_gen_param u_big (
        .px_clk(px_clk), .rst_n(rst_n), .en(en_b),
        .hsync(b_hsync), .vsync(b_vsync), .activevideo(b_av),
        .x_px(b_x), .y_px(b_y), .line_start(b_ls), .frame_start(b_fs),
        .vblank(b_vb), .frame_cnt(b_fc)
    );

    sync_vga_gen_param #(
        .H_ACTIVE(4), .H_FP(1), .H_PULSE(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_PULSE(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .CW(4), .FRAME_W(2)
    ) u_small (
        .px_clk(px_clk), .rst_n(rst_n), .en(en_s),
        .hsync(s_hsync), .vsync(s_vsync), .activevideo(s_av),
        .x_px(s_x), .y_px(s_y), .line_start(s_ls), .frame_start(s_fs),
        .vblank(s_vb), .frame_cnt(s_fc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Packing: hs vs av ls fs vb x[3:0] y[3:0] fc[1:0]
    function automatic logic [15:0] obs_s();
        return {s_hsync, s_vsync, s_av, s_ls, s_fs, s_vb, s_x, s_y, s_fc};
    endfunction

    // Small config: 8-cycle lines (4/1/2/1), 6-line frames (3/1/1/1).
    function automatic logic [15:0] exp_s(input int k, input int fc);
        int h;
        int v;
        logic av;
        logic [3:0] x;
        logic [3:0] y;
        h  = k % 8;
        v  = (k / 8) % 6;
        av = (h < 4) && (v < 3);
        x  = av ? 4'(h) : 4'd0;
        y  = av ? 4'(v) : 4'd0;
        return {(h == 5 || h == 6), (v != 4), av, (h == 0), (h == 0 && v == 0),
                (v >= 3), x, y, 2'(fc)};
    endfunction

    task automatic run_s(input int k0, input int n, input int fc, input string tag);
        for (int k = k0; k < k0 + n; k++) begin
            @(posedge px_clk); #1;
            chk($sformatf("%s_k%0d", tag, k), 32'(obs_s()), 32'(exp_s(k, fc)));
            if (s_ls) hpos = 0;
            else      hpos++;
            chk($sformatf("%s_align_hs_k%0d", tag, k), 32'(s_hsync), 32'(hpos == 5 || hpos == 6));
            chk($sformatf("%s_align_av_k%0d", tag, k), 32'(s_av), 32'(hpos < 4 && !s_vb));
        end
    endtask

    task automatic pause_s(input int n, input logic [15:0] held, input string tag);
        en_s = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge px_clk); #1;
            chk($sformatf("%s_hold%0d", tag, i), 32'(obs_s()), 32'(held & ~16'h1800));
        end
        en_s = 1'b1;
    endtask

    initial begin
        int h;
        int v;
        int lowcnt;
        int firstlow;
        logic [5:0]  ectl;
        logic [21:0] epos;

        rst_n = 1'b0;
        en_b  = 1'b0;
        en_s  = 1'b0;
        repeat (3) @(posedge px_clk);
        #1;
        chk("small_reset", 32'(obs_s()), 32'h4000);
        chk("big_reset_ctl", 32'({b_hsync, b_vsync, b_av, b_ls, b_fs, b_vb}), 32'b110000);
        chk("big_reset_pos", 32'({b_x, b_y, b_fc}), 32'h0);

        // Default timing: two full lines from the first enabled edge.
        rst_n    = 1'b1;
        en_b     = 1'b1;
        lowcnt   = 0;
        firstlow = -1;
        for (int k = 0; k < 2080; k++) begin
            @(posedge px_clk); #1;
            h    = k % 1040;
            v    = k / 1040;
            ectl = {!(h >= 856 && h < 976), 1'b1, (h < 800), (h == 0), (k == 0), 1'b0};
            epos = (h < 800) ? {11'(h), 11'(v)} : 22'h0;
            chk($sformatf("big_ctl_k%0d", k), 32'({b_hsync, b_vsync, b_av, b_ls, b_fs, b_vb}), 32'(ectl));
            chk($sformatf("big_pos_k%0d", k), 32'({b_x, b_y}), 32'(epos));
            if (!b_hsync && k < 1040) begin
                if (firstlow < 0) firstlow = k;
                lowcnt++;
            end
        end
        chk("big_hs_offset", 32'(firstlow), 32'd856);
        chk("big_hs_width", 32'(lowcnt), 32'd120);
        chk("big_frame_cnt", 32'(b_fc), 32'd0);
        chk("small_held_in_reset_state", 32'(obs_s()), 32'h4000);
        en_b = 1'b0;

        // Small config: five clean frames, frame_cnt 0,1,2,3,0.
        en_s = 1'b1;
        for (int f = 0; f < 5; f++) run_s(0, 48, f % 4, $sformatf("f%0d", f));

        // Pause 10 cycles at x_px=2; frame grows by 10.
        run_s(0, 3, 1, "f5a");
        pause_s(10, exp_s(2, 1), "f5p");
        run_s(3, 45, 1, "f5b");

        // Pause right after frame_start; strobes must drop.
        run_s(0, 1, 2, "f6a");
        pause_s(2, exp_s(0, 2), "f6p");
        run_s(1, 47, 2, "f6b");

        // Async reset mid-frame at vc=4.
        run_s(0, 34, 3, "f7");
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_immediate", 32'(obs_s()), 32'h4000);
        #2 rst_n = 1'b1;
        @(posedge px_clk); #1;
        chk("post_reset_first_edge", 32'(obs_s()), 32'(exp_s(0, 0)));
        @(posedge px_clk); #1;
        chk("post_reset_second_edge", 32'(obs_s()), 32'(exp_s(1, 0)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sync_vga_gen_param.md
Name: sync_vga_gen_param

Overview:
Parametrised VGA timing generator, successor to the fixed 800x600 sync generator.
- Any resolution/porch set, selectable sync polarity, clock enable, asynchronous active-low reset.
- All outputs fully registered and mutually aligned; adds line/frame strobes, vertical blank flag and a frame counter.
- Sits between the pixel clock source and the pixel renderers (pong, test patterns).

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 56, horizontal front porch (pixels)
H_PULSE, 120, hsync pulse width (pixels)
H_BP, 64, horizontal back porch (pixels)
V_ACTIVE, 600, visible lines per frame
V_FP, 37, vertical front porch (lines)
V_PULSE, 6, vsync pulse width (lines)
V_BP, 23, vertical back porch (lines)
HS_POL, 0, hsync asserted level (0 = active-low)
VS_POL, 0, vsync asserted level
CW, 11, width of counters and x_px/y_px
FRAME_W, 8, frame counter width

Ports:
px_clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
en  in  1  clock enable; low = freeze timing
hsync  out  1  horizontal sync, level per HS_POL
vsync  out  1  vertical sync, level per VS_POL
activevideo  out  1  high while (x_px, y_px) is visible
x_px  out  CW  visible column, 0 outside active
y_px  out  CW  visible row, 0 outside active
line_start  out  1  1-cycle strobe at hc=0 of every line
frame_start  out  1  1-cycle strobe at hc=0, vc=0
vblank  out  1  high while vc >= V_ACTIVE
frame_cnt  out  FRAME_W  completed-frame count, wraps mod 2^FRAME_W

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_PULSE+H_BP; V_TOTAL likewise.
- Elaboration error if H_TOTAL-1 or V_TOTAL-1 exceeds 2^CW-1, or if any pulse width is 0.
- Line order is active, front porch, pulse, back porch. hc/vc start at 0 = first visible pixel/line.
- Counters:
  - hc increments when en=1; wraps H_TOTAL-1 -> 0.
  - On the hc wrap, vc increments; wraps V_TOTAL-1 -> 0.
  - On the vc wrap, frame_cnt increments.
- Output registration: outputs are registered decodes of the current hc/vc, so every output reflects one (hc, vc) pair and they are mutually aligned. Latency is one px_clk from counter state to outputs.
- activevideo = (hc < H_ACTIVE) && (vc < V_ACTIVE). x_px = hc and y_px = vc when active, else 0.
- hsync = HS_POL for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_PULSE), else ~HS_POL.
- vsync = VS_POL for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_PULSE), else ~VS_POL. vsync edges coincide with hc=0.
- line_start = en && hc==0. frame_start = en && hc==0 && vc==0.
- frame_cnt output: first frame after reset shows 0; the frame_start of the second frame shows 1.
- Reset (asynchronous, any time, including mid-frame):
  - hc=vc=0, frame_cnt=0.
  - hsync=~HS_POL, vsync=~VS_POL.
  - activevideo, x_px, y_px, line_start, frame_start, vblank all 0.
- First rising edge with en=1 after rst_n release: activevideo=1, x_px=0, y_px=0, line_start=1, frame_start=1.
- en=0: counters and level outputs (syncs, activevideo, x/y, vblank, frame_cnt) hold. line_start and frame_start go 0, so a strobe never lasts more than one cycle. On re-enable, timing resumes exactly where it stopped.
- Simultaneous hc and vc wrap: frame_cnt increments on the same edge; no extra strobe.

Test Plan:
- Defaults, reset then en=1 for 2 frames:
  - H_TOTAL=1040, V_TOTAL=666.
  - hsync low for exactly 120 cycles, starting 856 cycles after each line_start.
  - frame_start period 692640 cycles.
  - frame_cnt: 0 then 1.
- Small config (H 4/1/2/1, V 3/1/1/1, HS_POL=1, VS_POL=0):
  - 8-cycle lines, 48-cycle frames.
  - activevideo high 4 cycles on lines 0-2 with x_px 0,1,2,3.
  - hsync high at hc 5-6.
  - vsync low during line 4 only.
  - vblank high lines 3-5.
- Alignment check: on every cycle, activevideo equals (x_px,y_px) lying in the visible region, and hsync matches the hc implied by the line_start count.
- en toggle: drop en for 10 cycles mid-line at x_px=2.
  - Outputs hold; strobes stay 0.
  - After re-enable, x_px continues 3 and frame length grows by exactly 10 cycles.
- Reset mid-frame: assert rst_n=0 asynchronously at vc=4.
  - Outputs go immediately to reset values without waiting for a clock edge.
  - After release, first edge gives frame_start=1, frame_cnt=0.
- frame_cnt wrap with FRAME_W=2 on the small config: values 0,1,2,3,0 across 5 frames.
